stage_memory: RTL and testbench

Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage. Consumes the EX/MEM latch (ALU result as address, forwarded rs2 as store data, load/store control), drives the data-memory port with aligned address, byte mask and shifted write data, and returns the sign- or zero-extended load result to the MEM/WB latch. A three-state controller holds the request until `dmem_resp` arrives, raises `mem_stall` for the hazard unit, and keeps a completed result stable until the pipeline advances.

---
 rtl/stage_memory_if.sv | 21 ++
 rtl/stage_memory.sv | 120 ++++++++++++
 tb/tb_stage_memory.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_memory_if.sv
// Data-memory port of the memory stage: request side driven by the stage,
// read data and completion returned by the memory.
interface stage_memory_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/stage_memory.sv
// RV32I memory stage: aligns loads/stores onto the data-memory port and holds
// the request (and, if the pipeline is not advancing, the result) until done.
module stage_memory (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          alu_out_ex_mem_i,
  input  logic [31:0]          rs2_ex_mem_i,
  input  logic                 advance_i,
  stage_memory_if.master       dmem,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_stall_o,
  output logic                 misaligned_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off;
  logic        access, op, req_en, rd_req, wr_req, resp, adv;
  logic        is_half, is_word;
  logic [31:0] load_val;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  boff,
                                              input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{boff, 3'b000} +: 8];
    h = word[{boff[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   load_extend = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] boff);
    case (size)
      2'b00:   store_mask = 4'b0001 << boff;
      2'b01:   store_mask = 4'b0011 << {boff[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] data, input logic [1:0] size,
                                             input logic [1:0] boff);
    store_data = (size == 2'b10) ? data : (data << {boff, 3'b000});
  endfunction

  always_comb begin
    off          = alu_out_ex_mem_i[1:0];
    is_half      = (funct3_i[1:0] == 2'b01);
    is_word      = (funct3_i[1:0] == 2'b10);
    access       = valid_i & (mem_read_i | mem_write_i);
    misaligned_o = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    op           = access & ~misaligned_o;
    // A completed op stays on the inputs while held in DONE; it must not reissue.
    req_en       = op & (state_q != S_DONE);
    rd_req       = mem_read_i & req_en;
    wr_req       = mem_write_i & req_en;
    resp         = dmem.dmem_resp;

    dmem.dmem_read    = rd_req;
    dmem.dmem_write   = wr_req;
    dmem.dmem_address = valid_i ? {alu_out_ex_mem_i[31:2], 2'b00} : 32'd0;
    dmem.dmem_wmask   = wr_req ? store_mask(funct3_i[1:0], off) : 4'b0000;
    dmem.dmem_wdata   = wr_req ? store_data(rs2_ex_mem_i, funct3_i[1:0], off) : 32'd0;

    load_val    = load_extend(dmem.dmem_rdata, off, funct3_i);
    mem_stall_o = ((state_q == S_IDLE) & op & ~resp) | ((state_q == S_WAIT) & ~resp);
    adv         = advance_i & ~mem_stall_o;

    if (state_q == S_DONE)  mem_rdata_o = rdata_q;
    else if (rd_req & resp) mem_rdata_o = load_val;
    else                    mem_rdata_o = 32'd0;

    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (op & ~resp) begin
          state_d = S_WAIT;
        end else if (op & resp & ~adv) begin
          state_d = S_DONE;
          rdata_d = mem_read_i ? load_val : 32'd0;
        end
      end
      S_WAIT: begin
        if (resp & adv) begin
          state_d = S_IDLE;
        end else if (resp) begin
          state_d = S_DONE;
          rdata_d = mem_read_i ? load_val : 32'd0;
        end
      end
      S_DONE: begin
        if (adv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized and directed bench for stage_memory against a transaction-level model.
module tb_stage_memory;
  logic        clk;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i, advance_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_out_ex_mem_i, rs2_ex_mem_i;
  logic [31:0] mem_rdata_o;
  logic        mem_stall_o, misaligned_o;

  stage_memory_if dm();

  stage_memory dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .mem_read_i       (mem_read_i),
    .mem_write_i      (mem_write_i),
    .funct3_i         (funct3_i),
    .alu_out_ex_mem_i (alu_out_ex_mem_i),
    .rs2_ex_mem_i     (rs2_ex_mem_i),
    .advance_i        (advance_i),
    .dmem             (dm),
    .mem_rdata_o      (mem_rdata_o),
    .mem_stall_o      (mem_stall_o),
    .misaligned_o     (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: an issued request not yet answered, and a finished result parked
  // because the pipeline did not advance.
  bit          m_outstanding;
  bit          m_parked;
  logic [31:0] m_parked_val;

  logic [31:0] smp_rdata, smp_wdata, smp_addr;
  logic [3:0]  smp_wmask;
  logic        smp_rd, smp_wr, smp_stall, smp_mis;
  int          cnt_rd, cnt_stall;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int o, input logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'b000: begin v = (w >> (8 * o)) & 32'hFF;  if (v >= 32'd128)   v = v - 32'd256;   end
      3'b100: v = (w >> (8 * o)) & 32'hFF;
      3'b001: begin v = (w >> (16 * (o / 2))) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b101: v = (w >> (16 * (o / 2))) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input int o);
    if (f3 == 3'b000) return 4'(1 << o);
    if (f3 == 3'b001) return 4'(3 << (2 * (o / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d, input int o);
    return (f3 == 3'b010) ? d : (d << (8 * o));
  endfunction

  function automatic bit ref_mis(input logic v, rd, wr, input logic [2:0] f3, input int o);
    bit half, word;
    half = (f3 == 3'b001) || (f3 == 3'b101);
    word = (f3 == 3'b010);
    return v && (rd || wr) && ((half && (o % 2 == 1)) || (word && o != 0));
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    int          o;
    bit          mis, op, e_rd, e_wr, e_stall, adv, resp;
    logic [31:0] ld, e_rdata;
    @(negedge clk);
    o       = int'(alu_out_ex_mem_i[1:0]);
    resp    = dm.dmem_resp;
    mis     = ref_mis(valid_i, mem_read_i, mem_write_i, funct3_i, o);
    op      = valid_i && (mem_read_i || mem_write_i) && !mis;
    e_rd    = op && mem_read_i && !m_parked;
    e_wr    = op && mem_write_i && !m_parked;
    e_stall = (op && !m_parked && !m_outstanding && !resp) || (m_outstanding && !resp);
    ld      = ref_load(dm.dmem_rdata, o, funct3_i);
    e_rdata = m_parked ? m_parked_val : ((e_rd && resp) ? ld : 32'd0);
    chk("misaligned", 32'(misaligned_o), 32'(mis));
    chk("dmem_read", 32'(dm.dmem_read), 32'(e_rd));
    chk("dmem_write", 32'(dm.dmem_write), 32'(e_wr));
    chk("mem_stall", 32'(mem_stall_o), 32'(e_stall));
    chk("mem_rdata", mem_rdata_o, e_rdata);
    chk("dmem_address", dm.dmem_address, valid_i ? (alu_out_ex_mem_i & 32'hFFFF_FFFC) : 32'd0);
    chk("dmem_wmask", 32'(dm.dmem_wmask), e_wr ? 32'(ref_mask(funct3_i, o)) : 32'd0);
    chk("dmem_wdata", dm.dmem_wdata, e_wr ? ref_wdata(funct3_i, rs2_ex_mem_i, o) : 32'd0);
    if (advance_i && mem_stall_o) chk("advance_during_stall", 32'd1, 32'd0);
    smp_rdata = mem_rdata_o;  smp_wdata = dm.dmem_wdata; smp_addr = dm.dmem_address;
    smp_wmask = dm.dmem_wmask; smp_rd = dm.dmem_read;   smp_wr = dm.dmem_write;
    smp_stall = mem_stall_o;  smp_mis = misaligned_o;
    if (smp_rd) cnt_rd++;
    if (smp_stall) cnt_stall++;
    adv = advance_i && !e_stall;
    @(posedge clk);
    if (rst) begin
      m_outstanding = 0; m_parked = 0; m_parked_val = 0;
    end else if (m_parked) begin
      if (adv) m_parked = 0;
    end else if (op && (m_outstanding || !resp)) begin
      m_outstanding = !resp;
      if (resp && !adv) begin m_parked = 1; m_parked_val = mem_read_i ? ld : 32'd0; end
    end else if (op && !adv) begin
      m_parked = 1; m_parked_val = mem_read_i ? ld : 32'd0;
    end
    #1;
  endtask

  // One instruction through the stage; memory answers after lat cycles and
  // the pipeline advances hold cycles after that.
  task automatic run_txn(input logic v, rd, wr, input logic [2:0] f3,
                         input logic [31:0] addr, rs2, rdat, input int lat, hold,
                         input bit spot_en, input logic [31:0] spot, input logic [3:0] spot_mask);
    valid_i = v; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_out_ex_mem_i = addr; rs2_ex_mem_i = rs2;
    cnt_rd = 0; cnt_stall = 0;
    if (!(v && (rd || wr)) || ref_mis(v, rd, wr, f3, int'(addr[1:0]))) begin
      advance_i = 1'b1; dm.dmem_resp = 1'($urandom_range(0, 1)); dm.dmem_rdata = $urandom;
      cyc();
      return;
    end
    for (int k = 0; k <= lat + hold; k++) begin
      dm.dmem_resp  = (k == lat);
      dm.dmem_rdata = (k == lat) ? rdat : $urandom;
      advance_i     = (k == lat + hold);
      cyc();
      if (spot_en && k == lat) begin
        if (rd) chk("spot_rdata", smp_rdata, spot);
        else begin
          chk("spot_wdata", smp_wdata, spot);
          chk("spot_wmask", 32'(smp_wmask), 32'(spot_mask));
        end
      end
    end
  endtask

  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind;
    rst = 1'b1; valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
    alu_out_ex_mem_i = 0; rs2_ex_mem_i = 0; advance_i = 0;
    dm.dmem_rdata = 0; dm.dmem_resp = 0;
    m_outstanding = 0; m_parked = 0; m_parked_val = 0;
    cyc();
    chk("reset_rdata", mem_rdata_o, 32'd0);
    chk("reset_stall", 32'(mem_stall_o), 32'd0);
    rst = 1'b0;

    run_txn(1, 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0, 1, 32'hDEADBEEF, 4'h0);
    chk("lw_read_cycles", 32'(cnt_rd), 32'd4);
    chk("lw_stall_cycles", 32'(cnt_stall), 32'd3);
    run_txn(1, 1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 1, 0, 1, 32'hFFFFFF80, 4'h0);
    chk("lb_address", smp_addr, 32'h100);
    run_txn(1, 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 0, 1, 32'h00000080, 4'h0);
    run_txn(1, 1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, 2, 0, 1, 32'hFFFF80FF, 4'h0);
    run_txn(1, 0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 1, 0, 1, 32'h0000AB00, 4'b0010);
    run_txn(1, 0, 1, 3'b001, 32'h102, 32'h00001234, 0, 0, 0, 1, 32'h12340000, 4'b1100);

    run_txn(1, 1, 0, 3'b010, 32'h200, 0, 32'h13579BDF, 0, 2, 1, 32'h13579BDF, 4'h0);
    chk("held_rdata", smp_rdata, 32'h13579BDF);
    chk("held_no_read", 32'(smp_rd), 32'd0);
    run_txn(1, 1, 0, 3'b010, 32'h204, 0, 32'h2468ACE0, 0, 0, 1, 32'h2468ACE0, 4'h0);
    chk("b2b_read_cycles", 32'(cnt_rd), 32'd1);

    run_txn(1, 1, 0, 3'b010, 32'h102, 0, 32'h11111111, 0, 0, 0, 0, 4'h0);
    chk("lw_mis_flag", 32'(smp_mis), 32'd1);
    chk("lw_mis_noreq", 32'(smp_rd), 32'd0);
    run_txn(1, 1, 0, 3'b001, 32'h101, 0, 32'h11111111, 0, 0, 0, 0, 4'h0);
    chk("lh_mis_flag", 32'(smp_mis), 32'd1);
    chk("lh_mis_rdata", smp_rdata, 32'd0);
    chk("lh_mis_stall", 32'(smp_stall), 32'd0);

    // Reset while a load is waiting on memory.
    valid_i = 1; mem_read_i = 1; mem_write_i = 0; funct3_i = 3'b010;
    alu_out_ex_mem_i = 32'h300; advance_i = 0; dm.dmem_resp = 0;
    cyc(); cyc();
    rst = 1'b1; valid_i = 0;
    m_outstanding = 0; m_parked = 0;
    #1;
    chk("rst_wait_read", 32'(dm.dmem_read), 32'd0);
    chk("rst_wait_stall", 32'(mem_stall_o), 32'd0);
    cyc();
    rst = 1'b0; dm.dmem_resp = 1; advance_i = 0;
    cyc();
    run_txn(1, 1, 0, 3'b010, 32'h304, 0, 32'hCAFEF00D, 1, 0, 1, 32'hCAFEF00D, 4'h0);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 4));
      if (kind == 0)
        run_txn(0, 1'($urandom_range(0, 1)), 0, 3'b010, $urandom, $urandom, $urandom, 0, 0, 0, 0, 4'h0);
      else if (kind <= 2)
        run_txn(1, 1, 0, ld_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0, 4'h0);
      else
        run_txn(1, 0, 1, st_f3[$urandom_range(0, 2)], $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
